spi_frame_receiver: RTL and testbench

- Front-end stage directly upstream of the SPI register-write logic that drives the PWM peripheral's enable and duty-cycle registers.
- Synchronises the asynchronous SCLK/COPI/nCS pins into the clk domain and detects SCLK rising edges.
- Assembles 16-bit SPI mode-0 frames MSB-first.
- Emits a one-cycle strobe carrying {rw, addr[6:0], data[7:0]} for well-formed frames, and an error strobe for malformed frames.

---
 rtl/spi_frame_receiver.sv | 157 +++++++++++++++
 tb/tb_spi_frame_receiver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver
//   Front end of the SPI register-write path that feeds the PWM peripheral.
//   Brings the asynchronous SCLK/COPI/nCS pins into the clk domain and
//   assembles SPI mode-0 frames, MSB first. A complete frame produces a
//   one-cycle frame_valid strobe carrying {rw, addr[6:0], data[7:0]}. A frame
//   that ends with any other bit count produces a one-cycle frame_err strobe.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   sclk_in      raw SPI clock pin (asynchronous)
//   copi_in      raw SPI data-in pin (asynchronous)
//   ncs_in       raw SPI chip-select pin, active-low (asynchronous)
//   frame_valid  one-cycle pulse: a well-formed frame was received
//   frame_rw     bit 15 of the last valid frame (1 = write)
//   frame_addr   bits 14:8 of the last valid frame
//   frame_data   bits 7:0 of the last valid frame
//   frame_err    one-cycle pulse: the frame ended with the wrong bit count
//   busy         high while a frame is in progress
module spi_frame_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       copi_in,
  input  logic       ncs_in,
  output logic       frame_valid,
  output logic       frame_rw,
  output logic [6:0] frame_addr,
  output logic [7:0] frame_data,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  logic [SYNC_STAGES-1:0] sclkSync_q;
  logic [SYNC_STAGES-1:0] copiSync_q;
  logic [SYNC_STAGES-1:0] ncsSync_q;
  logic                   sclkPrev_q;
  logic                   ncsPrev_q;
  logic [SYNC_STAGES:0]   realPipe_q;

  state_t                 state_q;
  logic [FRAME_BITS-1:0]  shreg_q;
  logic [FRAME_BITS-1:0]  shreg_d;
  logic [CNT_W-1:0]       bitCnt_q;
  logic [CNT_W-1:0]       bitCnt_d;

  logic sclkSync;
  logic copiSync;
  logic ncsSync;
  logic sclkRise;
  logic ncsFall;
  logic ncsRise;

  // Pin synchronisers plus one history flop per edge-detected pin.
  // realPipe_q marks when the history flop holds a genuinely sampled value.
  // The nCS chain resets to "deselected", so a pin that is already low when
  // reset releases would otherwise look like a falling edge and start a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclkSync_q <= '0;
      copiSync_q <= '0;
      ncsSync_q  <= '1;
      sclkPrev_q <= 1'b0;
      ncsPrev_q  <= 1'b1;
      realPipe_q <= '0;
    end else begin
      sclkSync_q <= {sclkSync_q[SYNC_STAGES-2:0], sclk_in};
      copiSync_q <= {copiSync_q[SYNC_STAGES-2:0], copi_in};
      ncsSync_q  <= {ncsSync_q[SYNC_STAGES-2:0], ncs_in};
      sclkPrev_q <= sclkSync;
      ncsPrev_q  <= ncsSync;
      realPipe_q <= {realPipe_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sclkSync = sclkSync_q[SYNC_STAGES-1];
  assign copiSync = copiSync_q[SYNC_STAGES-1];
  assign ncsSync  = ncsSync_q[SYNC_STAGES-1];

  assign sclkRise = sclkSync & ~sclkPrev_q;
  assign ncsFall  = ~ncsSync & ncsPrev_q & realPipe_q[SYNC_STAGES];
  assign ncsRise  = ncsSync & ~ncsPrev_q;

  // Next shift-register value and saturating bit count for one SCLK edge.
  // Saturating one past a full frame keeps an over-long frame distinguishable
  // from a complete one however many extra edges arrive.
  always_comb begin
    shreg_d  = {shreg_q[FRAME_BITS-2:0], copiSync};
    bitCnt_d = bitCnt_q;
    if (bitCnt_q != CNT_SAT) begin
      bitCnt_d = bitCnt_q + CNT_W'(1);
    end
  end

  // Frame FSM. The end of a frame takes priority over an SCLK edge seen in
  // the same cycle, so that edge is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitCnt_q    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_rw    <= 1'b0;
      frame_addr  <= '0;
      frame_data  <= '0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ncsFall) begin
            shreg_q  <= '0;
            bitCnt_q <= '0;
            state_q  <= RECV;
            busy     <= 1'b1;
          end
        end
        RECV: begin
          if (ncsRise) begin
            state_q <= IDLE;
            busy    <= 1'b0;
            if (bitCnt_q == CNT_DONE) begin
              frame_valid <= 1'b1;
              frame_rw    <= shreg_q[FRAME_BITS-1];
              frame_addr  <= shreg_q[FRAME_BITS-2 -: 7];
              frame_data  <= shreg_q[7:0];
            end else begin
              frame_err <= 1'b1;
            end
          end else if (sclkRise) begin
            shreg_q  <= shreg_d;
            bitCnt_q <= bitCnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb_spi_frame_receiver
//   Drives SPI mode-0 frames on the raw pins of spi_frame_receiver and checks
//   the strobes and frame fields against a word-level model of the receiver:
//   a frame of exactly 16 bits yields its value, anything else an error.
module tb_spi_frame_receiver;

  localparam int LATENCY = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       frame_valid;
  logic       frame_rw;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int vCnt = 0;
  int eCnt = 0;
  int bothCnt = 0;
  int busyCnt = 0;
  int vCyc = 0;
  logic vBusy = 1'b0;
  logic vPrevBusy = 1'b0;
  logic lastBusy = 1'b0;
  logic [15:0] vHist[$];

  logic [15:0] expWord = 16'h0000;

  spi_frame_receiver #(.SYNC_STAGES(2), .FRAME_BITS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk_in    (sclk),
    .copi_in    (copi),
    .ncs_in     (ncs),
    .frame_valid(frame_valid),
    .frame_rw   (frame_rw),
    .frame_addr (frame_addr),
    .frame_data (frame_data),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Pulse monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (frame_valid) begin
      vCnt++;
      vCyc = cyc;
      vBusy = busy;
      vPrevBusy = lastBusy;
      vHist.push_back({frame_rw, frame_addr, frame_data});
    end
    if (frame_err) eCnt++;
    if (frame_valid && frame_err) bothCnt++;
    if (busy) busyCnt++;
    lastBusy = busy;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Word-level model: a 16-bit frame becomes {rw, addr, data}.
  function automatic logic [15:0] modelWord(input int unsigned bits);
    int unsigned rw, addr, data;
    rw   = (bits / 32768) % 2;
    addr = (bits / 256) % 128;
    data = bits % 256;
    return 16'(rw * 32768 + addr * 256 + data);
  endfunction

  task automatic shiftBits(input int unsigned bits, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      copi = 1'((bits >> i) & 1);
      repeat (half) @(negedge clk);
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic sendFrame(input int unsigned bits, input int n, input int half,
                           input int gap, input bit coincide, output int riseCyc);
    @(negedge clk);
    ncs = 1'b0;
    if (coincide) begin
      sclk = 1'b1;
      repeat (half) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (half) @(negedge clk);
    shiftBits(bits, n, half);
    repeat (half) @(negedge clk);
    ncs = 1'b1;
    riseCyc = cyc;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", frame_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({frame_rw, frame_addr, frame_data} !== 16'h0000) begin errors++; $display("[TB] FAIL reset_fields: got %h expected 0000", {frame_rw, frame_addr, frame_data}); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int v0, e0, rise;
    v0 = vCnt; e0 = eCnt;
    sendFrame(32'h8480, 16, 4, 10, 1'b0, rise);
    expWord = modelWord(32'h8480);
    checks++; if (vCnt - v0 !== 1) begin errors++; $display("[TB] FAIL basic_valid_count: got %0d expected 1", vCnt - v0); end
    checks++; if (eCnt - e0 !== 0) begin errors++; $display("[TB] FAIL basic_err_count: got %0d expected 0", eCnt - e0); end
    checks++; if (vCyc - rise !== LATENCY) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", vCyc - rise, LATENCY); end
    checks++; if (vBusy !== 1'b0 || vPrevBusy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_fall: got %b%b expected 10", vPrevBusy, vBusy); end
    checks++; if (frame_rw !== 1'b1) begin errors++; $display("[TB] FAIL basic_rw: got %b expected 1", frame_rw); end
    checks++; if (frame_addr !== 7'h04) begin errors++; $display("[TB] FAIL basic_addr: got %h expected 04", frame_addr); end
    checks++; if (frame_data !== 8'h80) begin errors++; $display("[TB] FAIL basic_data: got %h expected 80", frame_data); end
  endtask

  task automatic test_bad_length(input int n);
    int v0, e0, rise;
    v0 = vCnt; e0 = eCnt;
    sendFrame($urandom, n, 4, 10, 1'b0, rise);
    checks++; if (eCnt - e0 !== 1) begin errors++; $display("[TB] FAIL len%0d_err_count: got %0d expected 1", n, eCnt - e0); end
    checks++; if (vCnt - v0 !== 0) begin errors++; $display("[TB] FAIL len%0d_valid_count: got %0d expected 0", n, vCnt - v0); end
    checks++; if ({frame_rw, frame_addr, frame_data} !== expWord) begin errors++; $display("[TB] FAIL len%0d_hold: got %h expected %h", n, {frame_rw, frame_addr, frame_data}, expWord); end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0, rise;
    v0 = vCnt; e0 = eCnt;
    @(negedge clk);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    shiftBits(32'hA5, 8, 4);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expWord = 16'h0000;
    shiftBits(32'h3C, 8, 4);
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (vCnt - v0 !== 0) begin errors++; $display("[TB] FAIL rstmid_valid_count: got %0d expected 0", vCnt - v0); end
    checks++; if (eCnt - e0 !== 0) begin errors++; $display("[TB] FAIL rstmid_err_count: got %0d expected 0", eCnt - e0); end
    checks++; if ({frame_rw, frame_addr, frame_data} !== expWord) begin errors++; $display("[TB] FAIL rstmid_fields: got %h expected %h", {frame_rw, frame_addr, frame_data}, expWord); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    v0 = vCnt;
    sendFrame(32'h0012, 16, 4, 10, 1'b0, rise);
    expWord = modelWord(32'h0012);
    checks++; if (vCnt - v0 !== 1) begin errors++; $display("[TB] FAIL rstmid_next_count: got %0d expected 1", vCnt - v0); end
    checks++; if ({frame_rw, frame_addr, frame_data} !== expWord) begin errors++; $display("[TB] FAIL rstmid_next_fields: got %h expected %h", {frame_rw, frame_addr, frame_data}, expWord); end
  endtask

  task automatic test_idle_sclk();
    int v0, e0, b0;
    v0 = vCnt; e0 = eCnt; b0 = busyCnt;
    ncs = 1'b1;
    for (int i = 0; i < 20; i++) begin
      copi = 1'($urandom_range(0, 1));
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (6) @(negedge clk);
    checks++; if (busyCnt - b0 !== 0) begin errors++; $display("[TB] FAIL idle_busy_cycles: got %0d expected 0", busyCnt - b0); end
    checks++; if (vCnt - v0 + eCnt - e0 !== 0) begin errors++; $display("[TB] FAIL idle_pulses: got %0d expected 0", vCnt - v0 + eCnt - e0); end
  endtask

  task automatic test_back_to_back();
    int v0, rise;
    v0 = vCnt;
    sendFrame(32'h8012, 16, 4, LATENCY, 1'b0, rise);
    sendFrame(32'h81F0, 16, 4, 10, 1'b0, rise);
    expWord = modelWord(32'h81F0);
    checks++; if (vCnt - v0 !== 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d expected 2", vCnt - v0); end
    if (vHist.size() >= 2) begin
      checks++; if (vHist[vHist.size() - 2] !== modelWord(32'h8012)) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 8012", vHist[vHist.size() - 2]); end
      checks++; if (vHist[vHist.size() - 1] !== expWord) begin errors++; $display("[TB] FAIL b2b_second: got %h expected %h", vHist[vHist.size() - 1], expWord); end
    end else begin
      checks++; errors++; $display("[TB] FAIL b2b_history: got %0d entries expected 2", vHist.size());
    end
  endtask

  task automatic test_coincident_edge();
    int v0, e0, rise;
    int unsigned w;
    v0 = vCnt; e0 = eCnt;
    w = $urandom & 32'hFFFF;
    sendFrame(w, 16, 4, 10, 1'b1, rise);
    expWord = modelWord(w);
    checks++; if (vCnt - v0 !== 1 || eCnt - e0 !== 0) begin errors++; $display("[TB] FAIL coincide_pulses: got v%0d e%0d expected v1 e0", vCnt - v0, eCnt - e0); end
    checks++; if ({frame_rw, frame_addr, frame_data} !== expWord) begin errors++; $display("[TB] FAIL coincide_fields: got %h expected %h", {frame_rw, frame_addr, frame_data}, expWord); end
  endtask

  task automatic test_random();
    int v0, e0, rise, n, half;
    int unsigned w;
    for (int k = 0; k < 12; k++) begin
      v0 = vCnt; e0 = eCnt;
      n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(12, 19)) : 16;
      half = int'($urandom_range(3, 6));
      w = $urandom & 32'h7FFFF;
      sendFrame(w, n, half, 10, 1'b0, rise);
      if (n == 16) expWord = modelWord(w);
      checks++; if (vCnt - v0 !== ((n == 16) ? 1 : 0) || eCnt - e0 !== ((n == 16) ? 0 : 1)) begin errors++; $display("[TB] FAIL rand%0d_pulses: got v%0d e%0d for %0d bits", k, vCnt - v0, eCnt - e0, n); end
      checks++; if ({frame_rw, frame_addr, frame_data} !== expWord) begin errors++; $display("[TB] FAIL rand%0d_fields: got %h expected %h", k, {frame_rw, frame_addr, frame_data}, expWord); end
      if (n == 16) begin
        checks++; if (vCyc - rise !== LATENCY) begin errors++; $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", k, vCyc - rise, LATENCY); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_length(15);
    test_bad_length(17);
    test_reset_mid_frame();
    test_idle_sclk();
    test_back_to_back();
    test_coincident_edge();
    test_random();
    checks++; if (bothCnt !== 0) begin errors++; $display("[TB] FAIL valid_and_err_together: got %0d expected 0", bothCnt); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
